// File: rtl/tlc_multi_phase_pkg.sv
// tlc_pkg: shared types and constants for the multi-phase traffic-light
// controller.
//   tlc_state_t  - controller state encoding
//   *_T_DEF      - default phase durations in clk cycles
//   dir_onehot() - one-hot lamp vector for an approach index (up to MAX_DIR)
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_ALL_RED,
    ST_GREEN,
    ST_YELLOW,
    ST_WALK,
    ST_FLASH
  } tlc_state_t;

  localparam int MAX_DIR      = 8;
  localparam int CNT_W_DEF    = 5;
  localparam int GREEN_T_DEF  = 20;
  localparam int YELLOW_T_DEF = 4;
  localparam int ALLRED_T_DEF = 2;
  localparam int WALK_T_DEF   = 10;

  // Callers truncate the result to their own NUM_DIR width.
  function automatic logic [MAX_DIR-1:0] dir_onehot(input logic [2:0] idx);
    logic [MAX_DIR-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tlc_multi_phase_if.sv
// tlc_multi_phase_if: request inputs and lamp outputs of the controller.
//   ped_req, flash                  - requests into the controller
//   green, yellow, red (NUM_DIR)    - lamp drive per approach
//   walk, ped_pending, cur_dir      - pedestrian lamp, latched request, approach index
// Modports: master = environment driving the requests, slave = controller.
interface tlc_multi_phase_if #(
  parameter int NUM_DIR = 2
);
  localparam int CUR_W = $clog2(NUM_DIR);

  logic               ped_req;
  logic               flash;
  logic [NUM_DIR-1:0] green;
  logic [NUM_DIR-1:0] yellow;
  logic [NUM_DIR-1:0] red;
  logic               walk;
  logic               ped_pending;
  logic [CUR_W-1:0]   cur_dir;

  modport master (
    output ped_req, flash,
    input  green, yellow, red, walk, ped_pending, cur_dir
  );

  modport slave (
    input  ped_req, flash,
    output green, yellow, red, walk, ped_pending, cur_dir
  );
endinterface

// File: rtl/tlc_multi_phase_timer.sv
// tlc_phase_timer: phase down-counter. A load sets the count to load_val;
// otherwise it decrements and holds at zero. done is high while the count is 0.
//   clk, rst (async, active-high) - clock and reset; reset loads RST_VAL
//   load, load_val                - synchronous reload
//   done                          - terminal count reached
module tlc_phase_timer #(
  parameter int               CNT_W   = 5,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/tlc_multi_phase.sv
// tlc_multi_phase: round-robin traffic-light controller for NUM_DIR approaches
// with all-red clearance, optional pedestrian walk phase and night-flash mode.
// Ports:
//   clk, rst (async, active-high)
//   bus (tlc_multi_phase_if.slave): ped_req, flash in; green, yellow, red,
//     walk, ped_pending, cur_dir out (all registered)
// Build option: define TLC_PED_EN to implement the pedestrian walk phase;
// without it ped_req is ignored and walk / ped_pending read 0.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_ALL_RED | clearance, every approach red
// ST_GREEN   | approach cur_dir green
// ST_YELLOW  | approach cur_dir yellow
// ST_WALK    | pedestrian walk, every approach red
// ST_FLASH   | night mode, all yellow blinking
module tlc_multi_phase
  import tlc_pkg::*;
#(
  parameter int NUM_DIR  = 2,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int GREEN_T  = GREEN_T_DEF,
  parameter int YELLOW_T = YELLOW_T_DEF,
  parameter int ALLRED_T = ALLRED_T_DEF,
  parameter int WALK_T   = WALK_T_DEF
) (
  input logic              clk,
  input logic              rst,
  tlc_multi_phase_if.slave bus
);

  localparam int CUR_W = $clog2(NUM_DIR);
  localparam int T_MAX = 1 << CNT_W;

  if (NUM_DIR < 2 || NUM_DIR > MAX_DIR) begin : g_bad_num_dir
    $error("tlc_multi_phase: NUM_DIR must be in 2..8");
  end
  if (GREEN_T < 1 || GREEN_T > T_MAX || YELLOW_T < 1 || YELLOW_T > T_MAX ||
      ALLRED_T < 1 || ALLRED_T > T_MAX || WALK_T < 1 || WALK_T > T_MAX) begin : g_bad_dur
    $error("tlc_multi_phase: every duration must be in 1..2**CNT_W");
  end

  // Timer reload values: a phase of T cycles counts T-1 down to 0.
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CUR_W-1:0] LAST_DIR  = CUR_W'(NUM_DIR - 1);

  tlc_state_t         state_q, state_d;
  logic [CUR_W-1:0]   dir_q, dir_d;
  logic               flash_on_q, flash_on_d;
  logic [NUM_DIR-1:0] green_q, green_d;
  logic [NUM_DIR-1:0] yellow_q, yellow_d;
  logic [NUM_DIR-1:0] red_q, red_d;
  logic [NUM_DIR-1:0] dir_oh_d;
  logic               tmr_done;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
`ifdef TLC_PED_EN
  localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(WALK_T - 1);
  logic               ped_q, ped_d;
  logic               walk_q, walk_d;
`endif

  tlc_phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(ALLRED_LD)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  // Every state either leaves or (in FLASH) toggles at terminal count, so the
  // timer reloads exactly when it is done.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    flash_on_d = flash_on_q;
    tmr_load   = tmr_done;
    tmr_val    = ALLRED_LD;
    if (tmr_done) begin
      case (state_q)
        ST_ALL_RED: begin
          if (bus.flash) begin
            state_d    = ST_FLASH;
            flash_on_d = 1'b1;
            tmr_val    = YELLOW_LD;
          end
`ifdef TLC_PED_EN
          else if (ped_q) begin
            state_d = ST_WALK;
            tmr_val = WALK_LD;
          end
`endif
          else begin
            state_d = ST_GREEN;
            dir_d   = (dir_q == LAST_DIR) ? '0 : dir_q + CUR_W'(1);
            tmr_val = GREEN_LD;
          end
        end
        ST_GREEN: begin
          state_d = ST_YELLOW;
          tmr_val = YELLOW_LD;
        end
        ST_FLASH: begin
          if (bus.flash) begin
            flash_on_d = ~flash_on_q;
            tmr_val    = YELLOW_LD;
          end else begin
            state_d    = ST_ALL_RED;
            flash_on_d = 1'b0;
          end
        end
        default: state_d = ST_ALL_RED;  // YELLOW and WALK both clear to all-red
      endcase
    end
  end

`ifdef TLC_PED_EN
  // Entering WALK wins over a same-edge press; presses during WALK are dropped.
  always_comb begin
    ped_d = ped_q;
    if (state_q == ST_WALK) begin
      ped_d = ped_q;
    end else if (state_d == ST_WALK) begin
      ped_d = 1'b0;
    end else if (bus.ped_req) begin
      ped_d = 1'b1;
    end
  end
`endif

  assign dir_oh_d = NUM_DIR'(dir_onehot(3'(dir_d)));

  // Lamps are decoded from the next state so they change on the transition edge.
  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    red_d    = '1;
`ifdef TLC_PED_EN
    walk_d   = (state_d == ST_WALK);
`endif
    case (state_d)
      ST_GREEN: begin
        green_d = dir_oh_d;
        red_d   = ~dir_oh_d;
      end
      ST_YELLOW: begin
        yellow_d = dir_oh_d;
        red_d    = ~dir_oh_d;
      end
      ST_FLASH: begin
        red_d    = '0;
        yellow_d = {NUM_DIR{flash_on_d}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ALL_RED;
      dir_q      <= LAST_DIR;
      flash_on_q <= 1'b0;
      green_q    <= '0;
      yellow_q   <= '0;
      red_q      <= '1;
`ifdef TLC_PED_EN
      ped_q      <= 1'b0;
      walk_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      flash_on_q <= flash_on_d;
      green_q    <= green_d;
      yellow_q   <= yellow_d;
      red_q      <= red_d;
`ifdef TLC_PED_EN
      ped_q      <= ped_d;
      walk_q     <= walk_d;
`endif
    end
  end

  assign bus.green   = green_q;
  assign bus.yellow  = yellow_q;
  assign bus.red     = red_q;
  assign bus.cur_dir = dir_q;
`ifdef TLC_PED_EN
  assign bus.walk        = walk_q;
  assign bus.ped_pending = ped_q;
`else
  assign bus.walk        = 1'b0;
  assign bus.ped_pending = 1'b0;
`endif

endmodule

// File: doc/tlc_multi_phase.md
# tlc_multi_phase

Parametrised traffic-light controller for an intersection of NUM_DIR approaches, each getting green in round-robin. Adds an all-red clearance interval, an optional pedestrian walk phase and a night-flash mode. It sits at the top of the light-control path as a drop-in successor to the two-block controller/datapath pair, with one internal down-counter timer.

## Interface
- NUM_DIR, default 2: number of approaches; legal range 2..8.
- CNT_W, default 5: timer width.
- GREEN_T, default 20: green duration, in clk cycles.
- YELLOW_T, default 4: yellow duration, in cycles; also the flash half-period.
- ALLRED_T, default 2: all-red clearance duration, in cycles.
- WALK_T, default 10: pedestrian walk duration, in cycles.
- All durations must satisfy 1 ≤ T ≤ 2^CNT_W. Elaboration fails otherwise.
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- ped_req, in, 1: pedestrian button, a level sampled each cycle.
- flash, in, 1: night-mode request.
- green, out, NUM_DIR: one-hot green per approach.
- yellow, out, NUM_DIR: yellow per approach.
- red, out, NUM_DIR: red per approach.
- walk, out, 1: pedestrian walk lamp.
- ped_pending, out, 1: latched pedestrian request.
- cur_dir, out, $clog2(NUM_DIR): index of the approach currently or last served.

## Operation
- Moore FSM with states ALL_RED, GREEN, YELLOW, WALK and FLASH. All outputs are registered and decoded from the state and cur_dir.
- Lamp rules:
  - GREEN: green[cur_dir]=1, all other approaches red.
  - YELLOW: yellow[cur_dir]=1, all other approaches red.
  - ALL_RED and WALK: red all ones. In WALK, walk=1.
  - FLASH: red=0, green=0, yellow is all ones or all zeros, toggling.
- Transitions:
  - GREEN→YELLOW after GREEN_T cycles.
  - YELLOW→ALL_RED after YELLOW_T cycles.
  - ALL_RED at timer done goes, in priority order:
    1. flash=1 → FLASH.
    2. ped_pending=1 → WALK.
    3. Otherwise → GREEN, with cur_dir advanced by one.
  - WALK→ALL_RED after WALK_T cycles. cur_dir is not advanced, so the next ALL_RED continues the rotation.
  - FLASH: yellow toggles every YELLOW_T cycles. At a toggle boundary with flash=0, go to ALL_RED.
- cur_dir wraps from NUM_DIR-1 to 0.
- ped_pending handling:
  - Set when ped_req=1.
  - Cleared on the edge that enters WALK. A ped_req on that same edge is absorbed; it is not re-latched.
  - ped_req during WALK is ignored.
- flash is sampled only at ALL_RED timer done. A running green/yellow sequence is never cut short.
- There is never more than one non-red approach at a time.

## Timing
- Reset values: state=ALL_RED, red=all ones, green=0, yellow=0, walk=0, ped_pending=0, cur_dir=NUM_DIR-1, timer loaded with ALLRED_T-1.
- First green after reset release is dir 0. Its green appears on the edge after ALLRED_T cycles of ALL_RED.
- Each state lasts exactly its T cycles:
  - On state entry the timer loads T-1.
  - The timer decrements each cycle and flags done at 0.
  - The state changes on the edge where done=1.
- Lamp outputs change on the same edge as the state change. There are no combinational paths from input to output.
- Full cycle period, no pedestrian: NUM_DIR·(GREEN_T+YELLOW_T+ALLRED_T).
- rst asserted mid-phase forces the reset values immediately, asynchronously.

## Configuration
- TLC_PED_EN defined: ped_pending, the WALK state and the walk lamp are implemented as described.
- TLC_PED_EN undefined: WALK is absent, ped_req is ignored, and walk and ped_pending are tied to 0. The ports remain present.

## Structure
- tlc_pkg holds:
  - the state enum typedef (tlc_state_t);
  - default duration constants;
  - a function returning the NUM_DIR-bit one-hot vector for cur_dir.
- One sub-module, tlc_phase_timer. It is a CNT_W down-counter with inputs load and load_val, output done, clocked on clk and reset by rst.

## Test plan
- Default parameters, release rst: red=2'b11 for 2 cycles; then green=2'b01 for 20 cycles, yellow=2'b01 for 4, all red for 2, green=2'b10. Total period 52.
- NUM_DIR=4: cur_dir sequence 0,1,2,3,0. Every cycle, green|yellow has at most one bit set.
- TLC_PED_EN, one-cycle ped_req pulse during dir-0 green: ped_pending=1 until WALK entry. After dir-0 ALL_RED, walk=1 for 10 cycles with red=all ones, then ALL_RED, then dir-1 green.
- flash raised mid-green: the green/yellow sequence completes, then FLASH. yellow toggles all ones/all zeros every 4 cycles. Dropping flash returns via ALL_RED to the next approach.
- rst asserted mid-yellow: outputs take reset values before the next edge. The sequence restarts with dir 0 green after ALLRED_T cycles.
- TLC_PED_EN undefined, ped_req held at 1: walk stays 0 and timing is identical to the first scenario.
